// File: rtl/instr_encode_loader_pkg.sv
// Shared encodings for the instruction encode/load path: formats, opcodes,
// loader states, error codes and the field bundle fed to the packer.
package instr_encode_loader_pkg;

   typedef enum logic [1:0] {
      FMT_R   = 2'b00,
      FMT_I   = 2'b01,
      FMT_J   = 2'b10,
      FMT_ILL = 2'b11
   } fmt_e;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ACCEPT = 3'd1,
      S_WRITE  = 3'd2,
      S_DONE   = 3'd3,
      S_ERROR  = 3'd4
   } state_e;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
   localparam logic [1:0] ERR_OVERFLOW = 2'b10;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;

   typedef struct packed {
      fmt_e        fmt;
      logic [5:0]  op;
      logic [5:0]  funct;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [15:0] imm;
      logic [25:0] target;
   } instr_fields_t;

endpackage

// File: rtl/instr_encode_loader_if.sv
// Request channel and instruction-memory write port of the loader.
interface instr_encode_loader_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [1:0]  req_fmt_i;
   logic [5:0]  req_op_i;
   logic [5:0]  req_funct_i;
   logic [4:0]  req_rs_i;
   logic [4:0]  req_rt_i;
   logic [4:0]  req_rd_i;
   logic [4:0]  req_shamt_i;
   logic [15:0] req_imm_i;
   logic [25:0] req_target_i;
   logic        req_last_i;
   logic        imem_wr_en_o;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_data_o;
   logic        imem_ack_i;

   modport master (
      output req_valid_i, req_fmt_i, req_op_i, req_funct_i, req_rs_i, req_rt_i,
             req_rd_i, req_shamt_i, req_imm_i, req_target_i, req_last_i, imem_ack_i,
      input  req_ready_o, imem_wr_en_o, imem_addr_o, imem_data_o
   );

   modport slave (
      input  req_valid_i, req_fmt_i, req_op_i, req_funct_i, req_rs_i, req_rt_i,
             req_rd_i, req_shamt_i, req_imm_i, req_target_i, req_last_i, imem_ack_i,
      output req_ready_o, imem_wr_en_o, imem_addr_o, imem_data_o
   );
endinterface

// File: rtl/instr_field_pack.sv
// Combinational R/I/J packer with legality check; shared with the reference model.
module instr_field_pack
   import instr_encode_loader_pkg::*;
(
   input  instr_fields_t f,
   output logic [31:0]   word_o,
   output logic          legal_o
);

   always_comb begin
      word_o  = '0;
      legal_o = 1'b0;
      case (f.fmt)
         FMT_R: begin
            word_o  = {OP_SPECIAL, f.rs, f.rt, f.rd, f.shamt, f.funct};
            legal_o = 1'b1;
         end
         FMT_I: begin
            word_o  = {f.op, f.rs, f.rt, f.imm};
            // SPECIAL and the jump opcodes would be misdecoded as R/J words
            legal_o = !(f.op == OP_SPECIAL || f.op == OP_J || f.op == OP_JAL);
         end
         FMT_J: begin
            word_o  = {f.op, f.target};
            legal_o = (f.op == OP_J) || (f.op == OP_JAL);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/instr_encode_loader.sv
// Session FSM: accepts field requests, packs them, and writes consecutive
// words into instruction memory through an acknowledged port.
module instr_encode_loader
   import instr_encode_loader_pkg::*;
#(
   parameter int DEPTH = 1024
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start_i,
   input  logic [31:0]                base_addr_i,
   instr_encode_loader_if.slave       bus,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       err_o,
   output logic [1:0]                 err_code_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   state_e        state;
   logic [31:0]   addr_q;
   logic [31:0]   word_q;
   logic          last_q;
   logic [CW-1:0] count_q;
   logic [1:0]    err_q;

   instr_fields_t fields;
   logic [31:0]   pack_word;
   logic          pack_legal;
   logic [CW-1:0] count_nxt;

   assign fields = '{
      fmt:    fmt_e'(bus.req_fmt_i),
      op:     bus.req_op_i,
      funct:  bus.req_funct_i,
      rs:     bus.req_rs_i,
      rt:     bus.req_rt_i,
      rd:     bus.req_rd_i,
      shamt:  bus.req_shamt_i,
      imm:    bus.req_imm_i,
      target: bus.req_target_i
   };

   instr_field_pack u_pack (
      .f       (fields),
      .word_o  (pack_word),
      .legal_o (pack_legal)
   );

   assign count_nxt = count_q + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         addr_q  <= '0;
         word_q  <= '0;
         last_q  <= 1'b0;
         count_q <= '0;
         err_q   <= ERR_NONE;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start_i) begin
                  addr_q  <= {base_addr_i[31:2], 2'b00};
                  count_q <= '0;
                  err_q   <= ERR_NONE;
                  state   <= S_ACCEPT;
               end
            end
            S_ACCEPT: begin
               if (bus.req_valid_i) begin
                  if (pack_legal) begin
                     word_q <= pack_word;
                     last_q <= bus.req_last_i;
                     state  <= S_WRITE;
                  end else begin
                     err_q <= ERR_ILLEGAL;
                     state <= S_ERROR;
                  end
               end
            end
            S_WRITE: begin
               // addr/data stay frozen in word_q/addr_q until the memory acks
               if (bus.imem_ack_i) begin
                  count_q <= count_nxt;
                  addr_q  <= addr_q + 32'd4;
                  if (last_q) begin
                     state <= S_DONE;
                  end else if (count_nxt == DEPTH_C) begin
                     err_q <= ERR_OVERFLOW;
                     state <= S_ERROR;
                  end else begin
                     state <= S_ACCEPT;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Outputs are pure decodes of registered state, never of req_* or ack.
   assign bus.req_ready_o  = (state == S_ACCEPT);
   assign bus.imem_wr_en_o = (state == S_WRITE);
   assign bus.imem_addr_o  = addr_q;
   assign bus.imem_data_o  = word_q;
   assign busy_o           = (state == S_ACCEPT) || (state == S_WRITE);
   assign done_o           = (state == S_DONE);
   assign err_o            = (state == S_ERROR);
   assign err_code_o       = err_q;
   assign count_o          = count_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader (DEPTH=4 so overflow is reachable).
module tb_instr_encode_loader;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_i;
   logic [31:0] base_addr_i;
   logic        busy_o, done_o, err_o;
   logic [1:0]  err_code_o;
   logic [2:0]  count_o;

   int tests_run = 0;
   int tests_failed = 0;

   instr_encode_loader_if bus ();

   instr_encode_loader #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .start_i     (start_i),
      .base_addr_i (base_addr_i),
      .bus         (bus),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .err_code_o  (err_code_o),
      .count_o     (count_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [1:0] fmt, input logic [5:0] op, input logic [5:0] funct,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [4:0] shamt, input logic [15:0] imm,
                          input logic [25:0] target, input logic last);
      bus.req_fmt_i    = fmt;
      bus.req_op_i     = op;
      bus.req_funct_i  = funct;
      bus.req_rs_i     = rs;
      bus.req_rt_i     = rt;
      bus.req_rd_i     = rd;
      bus.req_shamt_i  = shamt;
      bus.req_imm_i    = imm;
      bus.req_target_i = target;
      bus.req_last_i   = last;
      bus.req_valid_i  = 1'b1;
   endtask

   task automatic open_session(input logic [31:0] base);
      start_i     = 1'b1;
      base_addr_i = base;
      tick();
      start_i     = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tests_run++; if (bus.req_ready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b want 0", bus.req_ready_o); end
      tests_run++; if (bus.imem_wr_en_o !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_en: got %b want 0", bus.imem_wr_en_o); end
      tests_run++; if ({busy_o, done_o, err_o} !== 3'b000) begin tests_failed++; $display("FAIL reset_status: got %b want 000", {busy_o, done_o, err_o}); end
      tests_run++; if (err_code_o !== 2'b00 || count_o !== 3'd0) begin tests_failed++; $display("FAIL reset_code_count: got %b/%0d want 00/0", err_code_o, count_o); end
      tests_run++; if (bus.imem_addr_o !== 32'h0 || bus.imem_data_o !== 32'h0) begin tests_failed++; $display("FAIL reset_addr_data: got %h/%h want 0/0", bus.imem_addr_o, bus.imem_data_o); end
   endtask

   task automatic test_r_format();
      open_session(32'h0040_0000);
      tests_run++; if (bus.req_ready_o !== 1'b1 || busy_o !== 1'b1) begin tests_failed++; $display("FAIL r_accept: ready %b busy %b want 1 1", bus.req_ready_o, busy_o); end
      set_req(2'b00, 6'h3f, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
      tick();
      bus.req_valid_i = 1'b0;
      tests_run++; if (bus.imem_wr_en_o !== 1'b1) begin tests_failed++; $display("FAIL r_wr_en: got %b want 1", bus.imem_wr_en_o); end
      tests_run++; if (bus.imem_addr_o !== 32'h0040_0000) begin tests_failed++; $display("FAIL r_addr: got %h want 00400000", bus.imem_addr_o); end
      tests_run++; if (bus.imem_data_o !== 32'h0022_1820) begin tests_failed++; $display("FAIL r_data: got %h want 00221820", bus.imem_data_o); end
      bus.imem_ack_i = 1'b1;
      tick();
      bus.imem_ack_i = 1'b0;
      tests_run++; if (done_o !== 1'b1 || count_o !== 3'd1 || bus.imem_wr_en_o !== 1'b0) begin tests_failed++; $display("FAIL r_done: done %b count %0d wr %b want 1 1 0", done_o, count_o, bus.imem_wr_en_o); end
   endtask

   task automatic test_i_j_stall();
      open_session(32'h0040_0000);
      set_req(2'b01, 6'h08, 6'h0, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'h0, 1'b0);
      tick();
      bus.req_valid_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tests_run++; if (bus.imem_wr_en_o !== 1'b1 || bus.imem_addr_o !== 32'h0040_0000 || bus.imem_data_o !== 32'h2008_0005) begin tests_failed++; $display("FAIL i_stall%0d: wr %b addr %h data %h want 1 00400000 20080005", c, bus.imem_wr_en_o, bus.imem_addr_o, bus.imem_data_o); end
         tick();
      end
      bus.imem_ack_i = 1'b1;
      tick();
      bus.imem_ack_i = 1'b0;
      tests_run++; if (bus.req_ready_o !== 1'b1 || count_o !== 3'd1 || bus.imem_wr_en_o !== 1'b0) begin tests_failed++; $display("FAIL i_after_ack: ready %b count %0d wr %b want 1 1 0", bus.req_ready_o, count_o, bus.imem_wr_en_o); end
      set_req(2'b10, 6'h02, 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h010_0000, 1'b1);
      tick();
      bus.req_valid_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tests_run++; if (bus.imem_wr_en_o !== 1'b1 || bus.imem_addr_o !== 32'h0040_0004 || bus.imem_data_o !== 32'h0810_0000) begin tests_failed++; $display("FAIL j_stall%0d: wr %b addr %h data %h want 1 00400004 08100000", c, bus.imem_wr_en_o, bus.imem_addr_o, bus.imem_data_o); end
         tick();
      end
      bus.imem_ack_i = 1'b1;
      tick();
      bus.imem_ack_i = 1'b0;
      tests_run++; if (done_o !== 1'b1 || count_o !== 3'd2) begin tests_failed++; $display("FAIL j_done: done %b count %0d want 1 2", done_o, count_o); end
   endtask

   task automatic test_illegal();
      open_session(32'h0000_1000);
      set_req(2'b10, 6'h04, 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h123, 1'b1);
      tick();
      bus.req_valid_i = 1'b0;
      tests_run++; if (err_o !== 1'b1 || err_code_o !== 2'b01) begin tests_failed++; $display("FAIL ill_j_err: err %b code %b want 1 01", err_o, err_code_o); end
      tests_run++; if (bus.imem_wr_en_o !== 1'b0 || count_o !== 3'd0 || bus.req_ready_o !== 1'b0) begin tests_failed++; $display("FAIL ill_j_nowrite: wr %b count %0d ready %b want 0 0 0", bus.imem_wr_en_o, count_o, bus.req_ready_o); end
      tick();
      tests_run++; if (err_o !== 1'b1 || bus.imem_wr_en_o !== 1'b0) begin tests_failed++; $display("FAIL ill_hold: err %b wr %b want 1 0", err_o, bus.imem_wr_en_o); end
      open_session(32'h0000_1000);
      tests_run++; if (err_o !== 1'b0 || err_code_o !== 2'b00 || busy_o !== 1'b1) begin tests_failed++; $display("FAIL ill_restart: err %b code %b busy %b want 0 00 1", err_o, err_code_o, busy_o); end
      // I-format with the JAL opcode collides with J encodings
      set_req(2'b01, 6'h03, 6'h0, 5'd1, 5'd1, 5'd0, 5'd0, 16'h1, 26'h0, 1'b1);
      tick();
      bus.req_valid_i = 1'b0;
      tests_run++; if (err_o !== 1'b1 || err_code_o !== 2'b01 || bus.imem_wr_en_o !== 1'b0) begin tests_failed++; $display("FAIL ill_i_jal: err %b code %b wr %b want 1 01 0", err_o, err_code_o, bus.imem_wr_en_o); end
      open_session(32'h0000_1000);
      set_req(2'b11, 6'h08, 6'h0, 5'd1, 5'd1, 5'd0, 5'd0, 16'h1, 26'h0, 1'b1);
      tick();
      bus.req_valid_i = 1'b0;
      tests_run++; if (err_o !== 1'b1 || err_code_o !== 2'b01) begin tests_failed++; $display("FAIL ill_fmt3: err %b code %b want 1 01", err_o, err_code_o); end
   endtask

   task automatic test_overflow();
      open_session(32'h0000_2000);
      bus.imem_ack_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_req(2'b01, 6'h08, 6'h0, 5'd0, 5'(i), 5'd0, 5'd0, 16'(i), 26'h0, 1'b0);
         tick();
         bus.req_valid_i = 1'b0;
         tests_run++; if (bus.imem_wr_en_o !== 1'b1 || bus.imem_addr_o !== 32'h0000_2000 + 32'(4 * i)) begin tests_failed++; $display("FAIL ovf_write%0d: wr %b addr %h want 1 %h", i, bus.imem_wr_en_o, bus.imem_addr_o, 32'h0000_2000 + 32'(4 * i)); end
         tick();
      end
      tests_run++; if (err_o !== 1'b1 || err_code_o !== 2'b10 || count_o !== 3'd4) begin tests_failed++; $display("FAIL ovf_err: err %b code %b count %0d want 1 10 4", err_o, err_code_o, count_o); end
      set_req(2'b01, 6'h08, 6'h0, 5'd0, 5'd9, 5'd0, 5'd0, 16'h9, 26'h0, 1'b0);
      tick();
      tests_run++; if (bus.req_ready_o !== 1'b0 || bus.imem_wr_en_o !== 1'b0 || count_o !== 3'd4) begin tests_failed++; $display("FAIL ovf_fifth: ready %b wr %b count %0d want 0 0 4", bus.req_ready_o, bus.imem_wr_en_o, count_o); end
      bus.req_valid_i = 1'b0;
      bus.imem_ack_i  = 1'b0;
   endtask

   task automatic test_wrap();
      open_session(32'hFFFF_FFFC);
      bus.imem_ack_i = 1'b1;
      set_req(2'b01, 6'h08, 6'h0, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1, 26'h0, 1'b0);
      tick();
      bus.req_valid_i = 1'b0;
      tests_run++; if (bus.imem_addr_o !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_first: got %h want fffffffc", bus.imem_addr_o); end
      tick();
      set_req(2'b01, 6'h08, 6'h0, 5'd0, 5'd2, 5'd0, 5'd0, 16'h2, 26'h0, 1'b1);
      tick();
      bus.req_valid_i = 1'b0;
      tests_run++; if (bus.imem_addr_o !== 32'h0000_0000 || bus.imem_data_o !== 32'h2002_0002) begin tests_failed++; $display("FAIL wrap_second: addr %h data %h want 00000000 20020002", bus.imem_addr_o, bus.imem_data_o); end
      tick();
      tests_run++; if (done_o !== 1'b1 || count_o !== 3'd2) begin tests_failed++; $display("FAIL wrap_done: done %b count %0d want 1 2", done_o, count_o); end
      open_session(32'h0040_0003);
      set_req(2'b00, 6'h0, 6'h22, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1'b1);
      tick();
      bus.req_valid_i = 1'b0;
      tests_run++; if (bus.imem_addr_o !== 32'h0040_0000 || bus.imem_data_o !== 32'h0085_3022) begin tests_failed++; $display("FAIL unaligned_base: addr %h data %h want 00400000 00853022", bus.imem_addr_o, bus.imem_data_o); end
      tick();
      bus.imem_ack_i = 1'b0;
   endtask

   task automatic test_start_ignored_and_reset_mid_write();
      open_session(32'h0000_0100);
      set_req(2'b01, 6'h08, 6'h0, 5'd0, 5'd3, 5'd0, 5'd0, 16'h3, 26'h0, 1'b0);
      tick();
      bus.req_valid_i = 1'b0;
      bus.imem_ack_i  = 1'b1;
      tick();
      bus.imem_ack_i  = 1'b0;
      start_i     = 1'b1;
      base_addr_i = 32'h0000_0200;
      tick();
      start_i     = 1'b0;
      tests_run++; if (bus.req_ready_o !== 1'b1 || count_o !== 3'd1 || bus.imem_addr_o !== 32'h0000_0104) begin tests_failed++; $display("FAIL start_ignored: ready %b count %0d addr %h want 1 1 00000104", bus.req_ready_o, count_o, bus.imem_addr_o); end
      set_req(2'b01, 6'h08, 6'h0, 5'd0, 5'd4, 5'd0, 5'd0, 16'h4, 26'h0, 1'b0);
      tick();
      bus.req_valid_i = 1'b0;
      tests_run++; if (bus.imem_wr_en_o !== 1'b1 || bus.imem_addr_o !== 32'h0000_0104) begin tests_failed++; $display("FAIL second_write: wr %b addr %h want 1 00000104", bus.imem_wr_en_o, bus.imem_addr_o); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tests_run++; if (bus.imem_wr_en_o !== 1'b0 || bus.req_ready_o !== 1'b0 || {busy_o, done_o, err_o} !== 3'b000) begin tests_failed++; $display("FAIL midreset_ctrl: wr %b ready %b status %b want 0 0 000", bus.imem_wr_en_o, bus.req_ready_o, {busy_o, done_o, err_o}); end
      tests_run++; if (count_o !== 3'd0 || err_code_o !== 2'b00 || bus.imem_addr_o !== 32'h0 || bus.imem_data_o !== 32'h0) begin tests_failed++; $display("FAIL midreset_data: count %0d code %b addr %h data %h want 0 00 0 0", count_o, err_code_o, bus.imem_addr_o, bus.imem_data_o); end
   endtask

   initial begin
      reset       = 1'b1;
      start_i     = 1'b0;
      base_addr_i = 32'h0;
      bus.req_valid_i = 1'b0;
      bus.imem_ack_i  = 1'b0;
      set_req(2'b00, 6'h0, 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
      bus.req_valid_i = 1'b0;
      test_reset();
      test_r_format();
      test_i_j_stall();
      test_illegal();
      test_overflow();
      test_wrap();
      test_start_ignored_and_reset_mid_write();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
